// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit and its return-address stack.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_t;

    localparam int unsigned ILEN_BYTES    = 4;
    localparam logic [1:0]  MISALIGN_MASK = 2'b11;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop and replace-top with a saturating entry count.
module ras_stack #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            replace_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [XLEN-1:0]  mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // ptr_q is the next write slot; the top lives one below it, wrapping naturally.
    assign top_idx = ptr_q - PTR_W'(1);
    assign top_o   = mem_q[top_idx];
    assign valid_o = (cnt_q != '0);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i || (replace_i && (cnt_q == '0))) begin
            mem_d[ptr_q] = wdata_i;
            ptr_d        = ptr_q + PTR_W'(1);
            if (cnt_q != FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (replace_i) begin
            mem_d[top_idx] = wdata_i;
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-address generator: next-PC selection, misaligned-jump trapping, RAS hints and retire counter.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4,
    parameter int unsigned      CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       pc_sel,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic             link_push,
    input  logic             ret_pop,
    input  logic             trap_req,
    input  logic [XLEN-1:0]  trap_vec,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  link_addr,
    output logic             misalign,
    output logic [XLEN-1:0]  bad_addr,
    output logic [XLEN-1:0]  ras_top,
    output logic             ras_valid,
    output logic [CNT_W-1:0] instret
);

    pc_sel_t          sel;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  bad_q, bad_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  seq_addr, br_addr, jalr_addr, cand;
    logic             misaligned, commit;
    logic             ras_push, ras_pop, ras_replace;

    assign sel       = pc_sel_t'(pc_sel);
    assign link_addr = pc_q + XLEN'(ILEN_BYTES);

    // Candidate target; a target equal to the fall-through is never considered misaligned.
    always_comb begin
        seq_addr  = pc_q + XLEN'(ILEN_BYTES);
        br_addr   = pc_q + imm;
        jalr_addr = (rs1_val + imm) & ~XLEN'(1);
        case (sel)
            PC_BRANCH: cand = br_taken ? br_addr : seq_addr;
            PC_JAL:    cand = br_addr;
            PC_JALR:   cand = jalr_addr;
            default:   cand = seq_addr;
        endcase
        misaligned = (cand != seq_addr) && ((cand[1:0] & MISALIGN_MASK) != 2'b00);
    end

    always_comb begin
        pc_d      = pc_q;
        bad_d     = bad_q;
        mis_d     = 1'b0;
        instret_d = instret_q;
        commit    = 1'b0;
        if (enable) begin
            if (trap_req) begin
                pc_d = trap_vec;
            end else if (misaligned) begin
                pc_d  = trap_vec;
                bad_d = cand;
                mis_d = 1'b1;
            end else begin
                pc_d      = cand;
                instret_d = instret_q + CNT_W'(1);
                commit    = 1'b1;
            end
        end
        ras_push    = commit && link_push &&
                      ((sel == PC_JAL) || ((sel == PC_JALR) && !ret_pop));
        ras_pop     = commit && (sel == PC_JALR) && ret_pop && !link_push;
        ras_replace = commit && (sel == PC_JALR) && ret_pop && link_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            bad_q     <= '0;
            mis_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            pc_q      <= pc_d;
            bad_q     <= bad_d;
            mis_q     <= mis_d;
            instret_q <= instret_d;
        end
    end

    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push_i    (ras_push),
        .pop_i     (ras_pop),
        .replace_i (ras_replace),
        .wdata_i   (link_addr),
        .top_o     (ras_top),
        .valid_o   (ras_valid)
    );

    assign pc_out   = pc_q;
    assign bad_addr = bad_q;
    assign misalign = mis_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: expectations queued with each stimulus step, popped after the edge.
module tb_pc_unit;
    import pc_pkg::*;

    logic        clk, reset, enable, br_taken, link_push, ret_pop, trap_req;
    logic [1:0]  pc_sel;
    logic [31:0] imm, rs1_val, trap_vec;
    logic [31:0] pc_out, link_addr, bad_addr, ras_top;
    logic        misalign, ras_valid;
    logic [63:0] instret;

    pc_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .CNT_W(64)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pc_sel(pc_sel), .br_taken(br_taken),
        .imm(imm), .rs1_val(rs1_val), .link_push(link_push), .ret_pop(ret_pop),
        .trap_req(trap_req), .trap_vec(trap_vec), .pc_out(pc_out), .link_addr(link_addr),
        .misalign(misalign), .bad_addr(bad_addr), .ras_top(ras_top), .ras_valid(ras_valid),
        .instret(instret)
    );

    typedef struct {
        logic        en;
        pc_sel_t     sel;
        logic        tk;
        logic [31:0] im;
        logic [31:0] rs;
        logic        lp;
        logic        rp;
        logic        tr;
        logic [31:0] tv;
    } stim_t;

    typedef struct {
        logic [31:0] pc;
        logic [63:0] ir;
        logic        mis;
        logic [31:0] bad;
        logic        rv;
        logic [31:0] rt;
        logic        chk_rt;
    } exp_t;

    exp_t  sbq[$];
    stim_t st[$];
    exp_t  ex[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic stim_t mk(input logic en, input pc_sel_t sel, input logic tk,
                                 input logic [31:0] im, input logic [31:0] rs, input logic lp,
                                 input logic rp, input logic tr, input logic [31:0] tv);
        stim_t s;
        s.en = en; s.sel = sel; s.tk = tk; s.im = im; s.rs = rs;
        s.lp = lp; s.rp = rp; s.tr = tr; s.tv = tv;
        return s;
    endfunction

    function automatic exp_t mx(input logic [31:0] pc, input logic [63:0] ir, input logic mis,
                                input logic [31:0] bad, input logic rv, input logic [31:0] rt,
                                input logic chk_rt);
        exp_t e;
        e.pc = pc; e.ir = ir; e.mis = mis; e.bad = bad; e.rv = rv; e.rt = rt; e.chk_rt = chk_rt;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        enable = s.en; pc_sel = s.sel; br_taken = s.tk; imm = s.im; rs1_val = s.rs;
        link_push = s.lp; ret_pop = s.rp; trap_req = s.tr; trap_vec = s.tv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs the queued st/ex table: push expectation, drive, clock, pop and compare every output.
    task automatic run_table(input string tag);
        exp_t e;
        for (int i = 0; i < st.size(); i++) begin
            sbq.push_back(ex[i]);
            apply(st[i]);
            tick();
            e = sbq.pop_front();
            checks++;
            if (pc_out !== e.pc) begin
                errors++;
                $display("FAIL %s[%0d] pc_out got %h want %h", tag, i, pc_out, e.pc);
            end
            checks++;
            if (instret !== e.ir) begin
                errors++;
                $display("FAIL %s[%0d] instret got %0d want %0d", tag, i, instret, e.ir);
            end
            checks++;
            if (misalign !== e.mis || bad_addr !== e.bad) begin
                errors++;
                $display("FAIL %s[%0d] misalign/bad_addr got %b/%h want %b/%h",
                         tag, i, misalign, bad_addr, e.mis, e.bad);
            end
            checks++;
            if (ras_valid !== e.rv) begin
                errors++;
                $display("FAIL %s[%0d] ras_valid got %b want %b", tag, i, ras_valid, e.rv);
            end
            if (e.chk_rt) begin
                checks++;
                if (ras_top !== e.rt) begin
                    errors++;
                    $display("FAIL %s[%0d] ras_top got %h want %h", tag, i, ras_top, e.rt);
                end
            end
        end
        st.delete();
        ex.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        apply(mk(1'b0, PC_SEQ, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0));
        reset = 1'b1;
        sbq.push_back(mx(32'h0, 64'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        #3;
        e = sbq.pop_front();
        checks++;
        if (pc_out !== e.pc || instret !== e.ir || link_addr !== 32'h4) begin
            errors++;
            $display("FAIL reset pc/instret/link got %h/%0d/%h want %h/%0d/4",
                     pc_out, instret, link_addr, e.pc, e.ir);
        end
        checks++;
        if (misalign !== e.mis || bad_addr !== e.bad || ras_valid !== e.rv || ras_top !== e.rt) begin
            errors++;
            $display("FAIL reset mis/bad/rv/rt got %b/%h/%b/%h want 0/0/0/0",
                     misalign, bad_addr, ras_valid, ras_top);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_seq();
        for (int k = 1; k <= 3; k++) begin
            st.push_back(mk(1'b1, PC_SEQ, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0));
            ex.push_back(mx(32'(4 * k), 64'(k), 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        end
        run_table("seq");
    endtask

    task automatic test_branch();
        st.push_back(mk(1'b1, PC_SEQ,    1'b0, 32'h0,        '0, 1'b0, 1'b0, 1'b1, 32'h10));
        ex.push_back(mx(32'h10, 64'd3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        st.push_back(mk(1'b1, PC_BRANCH, 1'b1, 32'hFFFF_FFF8, '0, 1'b0, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h08, 64'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        st.push_back(mk(1'b1, PC_SEQ,    1'b0, 32'h0,        '0, 1'b0, 1'b0, 1'b1, 32'h10));
        ex.push_back(mx(32'h10, 64'd4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        st.push_back(mk(1'b1, PC_BRANCH, 1'b0, 32'hFFFF_FFF8, '0, 1'b0, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h14, 64'd5, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        st.push_back(mk(1'b0, PC_BRANCH, 1'b1, 32'hFFFF_FFF8, '0, 1'b0, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h14, 64'd5, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1));
        run_table("branch");
    endtask

    task automatic test_jal_ret();
        st.push_back(mk(1'b1, PC_SEQ,  1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b1, 32'h20));
        ex.push_back(mx(32'h20,  64'd5, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1));
        st.push_back(mk(1'b1, PC_JAL,  1'b0, 32'h100, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h120, 64'd6, 1'b0, 32'h0, 1'b1, 32'h24, 1'b1));
        st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0,   32'h24, 1'b0, 1'b1, 1'b0, 32'h0));
        ex.push_back(mx(32'h24,  64'd7, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0));
        run_table("jal_ret");
    endtask

    task automatic test_misalign();
        st.push_back(mk(1'b1, PC_JALR,   1'b0, 32'h0, 32'h203, 1'b1, 1'b0, 1'b0, 32'h100));
        ex.push_back(mx(32'h100, 64'd7, 1'b1, 32'h202, 1'b0, 32'h0, 1'b0));
        st.push_back(mk(1'b0, PC_SEQ,    1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h100, 64'd7, 1'b0, 32'h202, 1'b0, 32'h0, 1'b0));
        st.push_back(mk(1'b1, PC_BRANCH, 1'b1, 32'h6, 32'h0,   1'b0, 1'b0, 1'b0, 32'h180));
        ex.push_back(mx(32'h180, 64'd7, 1'b1, 32'h106, 1'b0, 32'h0, 1'b0));
        st.push_back(mk(1'b1, PC_SEQ,    1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0));
        ex.push_back(mx(32'h184, 64'd8, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0));
        run_table("misalign");
    endtask

    task automatic test_back_to_back();
        logic [31:0] pops [4] = '{32'h34, 32'h24, 32'h14, 32'h0};
        st.push_back(mk(1'b1, PC_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0));
        ex.push_back(mx(32'h0, 64'd8, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0));
        for (int k = 1; k <= 5; k++) begin
            st.push_back(mk(1'b1, PC_JAL, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0));
            ex.push_back(mx(32'(16 * k), 64'(8 + k), 1'b0, 32'h106, 1'b1, 32'(16 * (k - 1) + 4), 1'b1));
        end
        for (int k = 0; k < 5; k++) begin
            st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0, 32'h1000, 1'b0, 1'b1, 1'b0, 32'h0));
            ex.push_back(mx(32'h1000, 64'(14 + k), 1'b0, 32'h106, 1'(k < 3),
                            (k < 3) ? pops[k] : 32'h0, 1'(k < 3)));
        end
        run_table("ras_b2b");
    endtask

    task automatic test_coroutine();
        st.push_back(mk(1'b1, PC_SEQ,  1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h200));
        ex.push_back(mx(32'h200, 64'd18, 1'b0, 32'h106, 1'b0, 32'h0,   1'b0));
        st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0, 32'h300, 1'b1, 1'b1, 1'b0, 32'h0));
        ex.push_back(mx(32'h300, 64'd19, 1'b0, 32'h106, 1'b1, 32'h204, 1'b1));
        st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0, 32'h400, 1'b1, 1'b1, 1'b0, 32'h0));
        ex.push_back(mx(32'h400, 64'd20, 1'b0, 32'h106, 1'b1, 32'h304, 1'b1));
        st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0, 32'h500, 1'b0, 1'b1, 1'b0, 32'h0));
        ex.push_back(mx(32'h500, 64'd21, 1'b0, 32'h106, 1'b0, 32'h0,   1'b0));
        run_table("coroutine");
    endtask

    task automatic test_trap_reset();
        exp_t e;
        st.push_back(mk(1'b1, PC_JALR, 1'b0, 32'h0, 32'h203, 1'b0, 1'b0, 1'b1, 32'h600));
        ex.push_back(mx(32'h600, 64'd21, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0));
        run_table("trap_prio");
        apply(mk(1'b1, PC_SEQ, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        sbq.push_back(mx(32'h0, 64'd0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        e = sbq.pop_front();
        checks++;
        if (pc_out !== e.pc || instret !== e.ir) begin
            errors++;
            $display("FAIL async_reset pc/instret got %h/%0d want %h/%0d", pc_out, instret, e.pc, e.ir);
        end
        checks++;
        if (bad_addr !== e.bad || ras_valid !== e.rv || misalign !== e.mis) begin
            errors++;
            $display("FAIL async_reset bad/rv/mis got %h/%b/%b want 0/0/0", bad_addr, ras_valid, misalign);
        end
        tick();
        checks++;
        if (pc_out !== 32'h0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL reset_held pc/instret got %h/%0d want 0/0", pc_out, instret);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_branch();
        test_jal_ret();
        test_misalign();
        test_back_to_back();
        test_coroutine();
        test_trap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised successor to the core's program counter, used as the fetch-address generator.
- Holds the PC and selects the next PC: sequential, conditional branch, JAL, JALR or trap redirect.
- Detects misaligned jump targets and latches the faulting address.
- Keeps a small return-address stack (RAS) as a prediction source for a future pipelined fetch.
- Counts retired instructions.
- Sits between the decoder/ALU and instruction memory; advances only when enable is asserted.

Parameters:
XLEN, 32, datapath/address width
RESET_VECTOR, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address-stack entries (power of two, >=2)
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  commit current instruction and advance the PC this cycle
pc_sel  in  2  pc_sel_t: PC_SEQ=0, PC_BRANCH=1, PC_JAL=2, PC_JALR=3
br_taken  in  1  branch condition from the ALU; only sampled when pc_sel==PC_BRANCH
imm  in  XLEN  signed byte offset; decoder supplies the full immediate with bit0 already placed, so no shift here
rs1_val  in  XLEN  JALR base register value
link_push  in  1  rd is x1/x5 on JAL/JALR (push hint)
ret_pop  in  1  rs1 is x1/x5 on JALR (pop hint)
trap_req  in  1  external trap request
trap_vec  in  XLEN  trap handler address
pc_out  out  XLEN  current PC (registered)
link_addr  out  XLEN  pc_out+4 (combinational)
misalign  out  1  one-cycle pulse: misaligned jump target was taken
bad_addr  out  XLEN  last misaligned target (registered, sticky)
ras_top  out  XLEN  RAS top entry
ras_valid  out  1  RAS non-empty
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, active-high) sets these values:
  - pc_out=RESET_VECTOR, bad_addr=0, misalign=0, instret=0.
  - RAS count=0, so ras_valid=0 and ras_top=0.
  - RAS entries need not be cleared.
- Target computation, all arithmetic modulo 2^XLEN (wrap-around, no saturation):
  - seq = pc+4
  - br/jal = pc+imm
  - jalr = (rs1_val+imm) with bit0 cleared
- Candidate next PC:
  - PC_SEQ: seq
  - PC_BRANCH: br if br_taken, else seq
  - PC_JAL: jal
  - PC_JALR: jalr
- Misaligned: the candidate differs from seq and candidate[1:0]!=0. No compressed ISA.
- Update on rising clk with enable=1, in priority order:
  1. trap_req: pc<=trap_vec; no RAS change; instret unchanged; misalign=0.
  2. Misaligned: pc<=trap_vec; bad_addr<=candidate; misalign=1 for exactly that one cycle; no RAS change; instret unchanged.
  3. Otherwise: pc<=candidate; instret+=1 (wraps at 2^CNT_W); RAS updated as below.
- enable=0: all state holds; misalign drops to 0 on the next edge.
- RAS, applies only to PC_JAL/PC_JALR:
  - Push (JAL or JALR with link_push): write link_addr.
  - Pop (JALR with ret_pop and not link_push): remove top.
  - JALR with both link_push and ret_pop (coroutine): replace top with link_addr; count unchanged. If empty, behaves as a push.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - ras_top always reflects the entry at pointer-1 after the update.
- Latency: pc_out changes one cycle after the enabled edge. link_addr is combinational from pc_out.
- Reset asserted mid-operation overrides everything immediately (asynchronous).

Decomposition:
- Shared package pc_pkg:
  - pc_sel_t enum
  - ILEN_BYTES=4 constant
  - misalignment mask constant
- One sub-module, ras_stack: circular buffer with push, pop, replace, top, valid and saturating count, parametrised by XLEN and RAS_DEPTH.
- Next-PC selection and the counters stay in pc_unit.

Test Plan:
- Reset then 3 enabled PC_SEQ cycles -> pc_out 0x0, 0x4, 0x8, 0xC; instret=3.
- pc=0x10; PC_BRANCH, imm=-8:
  - br_taken=1 -> pc_out=0x8
  - br_taken=0 (repeated from pc=0x10) -> pc_out=0x14
  - enable=0 -> pc_out holds
- pc=0x20; PC_JAL, imm=0x100, link_push=1 -> pc_out=0x120, ras_top=0x24, ras_valid=1. Then PC_JALR, rs1_val=0x24, imm=0, ret_pop=1 -> pc_out=0x24, ras_valid=0.
- PC_JALR, rs1_val=0x203, imm=0 (target 0x202), trap_vec=0x100 -> pc_out=0x100, misalign pulses one cycle, bad_addr=0x202, instret unchanged.
- Five JAL pushes from pc 0x0, 0x10, 0x20, 0x30, 0x40 with RAS_DEPTH=4 -> count stays 4; four pops return 0x44, 0x34, 0x24, 0x14; fifth pop leaves ras_valid=0.
- trap_req together with a misaligned JALR -> pc_out=trap_vec, misalign=0, bad_addr unchanged. Then assert reset mid-cycle -> pc_out=RESET_VECTOR immediately, instret=0.
